seq_decoder: RTL and testbench
==============================

Name: seq_decoder

Overview:
Parametrised successor to the combinational instruction decoder. It owns the fetch/execute sequencing state machine and a return-address stack for JMS/BBL, and decodes the 4-bit opcode into datapath controls. It sits between the instruction register and the PC/accumulator/data-memory datapath of the Harvard CPU, replacing the external state ring plus combinational decoder.

Parameters:
ADDR_W, 8, width of PC and of return-stack entries
STACK_DEPTH, 4, number of return-address entries (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
start  input  1  leave HALT; ignored in other states
inst  input  4  opcode from instruction register
pc_in  input  ADDR_W  current PC value
state  output  4  one-hot: [0]FETCH [1]EXEC1 [2]EXEC2 [3]HALT
ir_load  output  1  load instruction register
acc_load  output  1  load accumulator
mux3  output  1  accumulator source = ALU
e  output  1  data-memory read enable
WrEn  output  1  data-memory write
pc_load  output  1  load PC
pc_src  output  1  PC load source: 0 = operand, 1 = ret_addr
pc_inc  output  1  increment PC
p  output  1  reserved, tied 0
alu_op  output  3  ALU function = inst[2:0] during ARM, else 0
ret_addr  output  ADDR_W  top of stack; 0 when empty
stack_err  output  1  sticky overflow/underflow flag

Behaviour:
- Opcodes: 0 LDI, 1 STA, 2 ADD, 3 JMP, 4 STP, 5 LDA, 6 JMS, 7 BBL, 8-15 ARM.
- Registered: the state register, the stack array, sp (0..STACK_DEPTH) and stack_err. All other outputs are combinational decodes of state, inst and sp.
- Reset: state=FETCH (0001), sp=0, all entries 0, stack_err=0. Reset wins over every other event, including mid-EXEC2 and in HALT.
- FETCH: ir_load=1, all other controls 0. Next state is EXEC1.
- EXEC1 controls:
  - LDI: acc_load.
  - STA: WrEn.
  - ADD/LDA: e.
  - JMP: pc_load with pc_src=0.
  - ARM: acc_load, mux3, alu_op=inst[2:0].
  - STP: no controls.
  - pc_inc=1 for every opcode except STP, JMP, a valid JMS and a valid BBL.
- EXEC1 next state: ADD and LDA go to EXEC2; STP goes to HALT; all others go to FETCH.
- EXEC2 (ADD/LDA only): acc_load=1, e=1, mux3=1 for ADD, 0 for LDA. Next state is FETCH.
- HALT: all controls 0. With start=1, next state is FETCH; otherwise stay in HALT.
- JMS in EXEC1, sp<STACK_DEPTH:
  - stack[sp] <= pc_in+1 (mod 2^ADDR_W), sp <= sp+1.
  - pc_load=1, pc_src=0.
- JMS with sp==STACK_DEPTH (overflow): no push, no load; pc_inc=1, stack_err<=1.
- BBL in EXEC1, sp>0:
  - pc_load=1, pc_src=1, ret_addr=stack[sp-1].
  - acc_load=1 with mux3=0 (immediate load).
  - sp <= sp-1.
- BBL with sp==0 (underflow): no pop, no load, acc unchanged; pc_inc=1, stack_err<=1.
- stack_err clears only on reset.
- e is 0 outside EXEC1/EXEC2 of LDA/ADD. WrEn only in EXEC1 of STA.
- Nested calls to full depth are legal. Push and pop never occur in the same cycle.

Optional Feature:
STACK_ERR_HALT_EN:
- Defined: an overflow or underflow in EXEC1 sends the next state to HALT instead of FETCH. pc_inc is suppressed in that cycle; stack_err is still set.
- Undefined: continue as a NOP with pc_inc, per Behaviour.

Test Plan:
1. Reset, then inst=0 (LDI) -> state 0001 then 0010; EXEC1 acc_load=1, pc_inc=1; back to 0001.
2. inst=2 (ADD) -> EXEC1 e=1; EXEC2 acc_load=1, e=1, mux3=1; 3-cycle instruction.
3. inst=4 (STP) -> HALT 1000; hold 5 cycles with no controls; start=1 -> FETCH.
4. ADDR_W=8: JMS with pc_in=0x10, then JMS with pc_in=0xFF -> stack holds 0x11, 0x00 (wrap); BBL -> pc_src=1, ret_addr=0x00, acc_load=1; second BBL -> ret_addr=0x11; sp=0.
5. STACK_DEPTH=4: five JMS -> fifth gives pc_load=0, pc_inc=1, stack_err=1, sp=4. Then BBL on an empty stack after four pops -> stack_err stays 1 and pc_load=0. With STACK_ERR_HALT_EN defined -> state goes to 1000.
6. reset asserted during EXEC2 of LDA with sp=2 -> next cycle state=0001, sp=0, ret_addr=0, stack_err=0.

Source files
------------

// File: rtl/seq_decoder.sv
// seq_decoder: fetch/execute sequencer, return-address stack and opcode decode for the Harvard CPU.
// Latency: registers state, stack, sp and stack_err; all control outputs decode combinationally from them and inst.
// Backpressure: none; one state step per clock, HALT is left only on start.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   start                leaves HALT (ignored elsewhere)
//   inst, pc_in          opcode from the IR, current PC
//   state                one-hot {HALT, EXEC2, EXEC1, FETCH}
//   ir_load .. alu_op    datapath controls
//   ret_addr             top of return stack (0 when empty)
//   stack_err            sticky overflow/underflow flag
//
// Optional build macro STACK_ERR_HALT_EN: a stack overflow/underflow in EXEC1 halts
// the machine (no pc_inc) instead of behaving as a NOP that increments the PC.
module seq_decoder #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        inst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [3:0]        state,
  output logic              ir_load,
  output logic              acc_load,
  output logic              mux3,
  output logic              e,
  output logic              WrEn,
  output logic              pc_load,
  output logic              pc_src,
  output logic              pc_inc,
  output logic              p,
  output logic [2:0]        alu_op,
  output logic [ADDR_W-1:0] ret_addr,
  output logic              stack_err
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [3:0] OP_LDI = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_JMP = 4'd3;
  localparam logic [3:0] OP_STP = 4'd4;
  localparam logic [3:0] OP_LDA = 4'd5;
  localparam logic [3:0] OP_JMS = 4'd6;
  localparam logic [3:0] OP_BBL = 4'd7;

  typedef enum logic [3:0] {
    S_FETCH = 4'b0001,
    S_EXEC1 = 4'b0010,
    S_EXEC2 = 4'b0100,
    S_HALT  = 4'b1000
  } state_t;

  state_t            state_q, state_d;
  logic [SP_W-1:0]   sp_q;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [IDX_W-1:0]  push_idx, top_idx;
  logic              stk_full, stk_empty, is_exec1;
  logic              do_push, do_pop, stk_fault;

  assign stk_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stk_empty = (sp_q == '0);
  // Index casts only drop bits that are zero whenever the index is actually used.
  assign push_idx  = IDX_W'(sp_q);
  assign top_idx   = IDX_W'(sp_q - SP_W'(1));
  assign ret_addr  = stk_empty ? '0 : stack_q[top_idx];

  assign is_exec1  = (state_q == S_EXEC1);
  assign do_push   = is_exec1 && (inst == OP_JMS) && !stk_full;
  assign do_pop    = is_exec1 && (inst == OP_BBL) && !stk_empty;
  assign stk_fault = is_exec1 && (((inst == OP_JMS) && stk_full) ||
                                  ((inst == OP_BBL) && stk_empty));

  assign state = state_q;
  assign p     = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      sp_q      <= '0;
      stack_err <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      // JMS and BBL are exclusive opcodes, so push and pop never coincide.
      if (do_push) begin
        stack_q[push_idx] <= pc_in + ADDR_W'(1);
        sp_q              <= sp_q + SP_W'(1);
      end else if (do_pop) begin
        sp_q <= sp_q - SP_W'(1);
      end
      if (stk_fault) stack_err <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_load  = 1'b0;
    acc_load = 1'b0;
    mux3     = 1'b0;
    e        = 1'b0;
    WrEn     = 1'b0;
    pc_load  = 1'b0;
    pc_src   = 1'b0;
    pc_inc   = 1'b0;
    alu_op   = 3'd0;
    case (state_q)
      S_FETCH: begin
        ir_load = 1'b1;
        state_d = S_EXEC1;
      end
      S_EXEC1: begin
        state_d = S_FETCH;
        if (inst[3]) begin
          acc_load = 1'b1;
          mux3     = 1'b1;
          alu_op   = inst[2:0];
          pc_inc   = 1'b1;
        end else begin
          case (inst)
            OP_LDI: begin acc_load = 1'b1; pc_inc = 1'b1; end
            OP_STA: begin WrEn = 1'b1; pc_inc = 1'b1; end
            OP_ADD, OP_LDA: begin
              e       = 1'b1;
              pc_inc  = 1'b1;
              state_d = S_EXEC2;
            end
            OP_JMP: pc_load = 1'b1;
            OP_STP: state_d = S_HALT;
            OP_JMS: begin
              if (!stk_full) begin
                pc_load = 1'b1;
              end else begin
`ifdef STACK_ERR_HALT_EN
                state_d = S_HALT;
`else
                pc_inc = 1'b1;
`endif
              end
            end
            OP_BBL: begin
              if (!stk_empty) begin
                // Return: PC from stack, accumulator takes the immediate.
                pc_load  = 1'b1;
                pc_src   = 1'b1;
                acc_load = 1'b1;
              end else begin
`ifdef STACK_ERR_HALT_EN
                state_d = S_HALT;
`else
                pc_inc = 1'b1;
`endif
              end
            end
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_EXEC2: begin
        acc_load = 1'b1;
        e        = 1'b1;
        mux3     = (inst == OP_ADD);
        state_d  = S_FETCH;
      end
      S_HALT: begin
        if (start) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_seq_decoder.sv
// tb_seq_decoder: randomized and directed bench for seq_decoder against an instruction-level model.
// Latency: each instruction is walked cycle by cycle (FETCH, EXEC1, optional EXEC2/HALT).
// Backpressure: none; inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_seq_decoder;

  localparam int AW    = 8;
  localparam int DEPTH = 4;

  localparam logic [11:0] B_IR  = 12'h800;
  localparam logic [11:0] B_ACC = 12'h400;
  localparam logic [11:0] B_MUX = 12'h200;
  localparam logic [11:0] B_E   = 12'h100;
  localparam logic [11:0] B_WR  = 12'h080;
  localparam logic [11:0] B_PL  = 12'h040;
  localparam logic [11:0] B_PS  = 12'h020;
  localparam logic [11:0] B_INC = 12'h010;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [3:0]    inst;
  logic [AW-1:0] pc_in;
  logic [3:0]    state;
  logic          ir_load, acc_load, mux3, e, WrEn, pc_load, pc_src, pc_inc, p;
  logic [2:0]    alu_op;
  logic [AW-1:0] ret_addr;
  logic          stack_err;

  int checks   = 0;
  int failures = 0;

  // Instruction-level reference: return stack as a queue plus sticky error.
  logic [AW-1:0] rq[$];
  bit            m_err;
  bit            halt_reset;

  seq_decoder #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .inst(inst), .pc_in(pc_in),
    .state(state), .ir_load(ir_load), .acc_load(acc_load), .mux3(mux3), .e(e),
    .WrEn(WrEn), .pc_load(pc_load), .pc_src(pc_src), .pc_inc(pc_inc), .p(p),
    .alu_op(alu_op), .ret_addr(ret_addr), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ctrl_now();
    return {ir_load, acc_load, mux3, e, WrEn, pc_load, pc_src, pc_inc, p, alu_op};
  endfunction

  function automatic logic [AW-1:0] model_top();
    if (rq.size() == 0) return '0;
    return rq[rq.size()-1];
  endfunction

  task automatic model_clear();
    rq.delete();
    m_err = 1'b0;
  endtask

  // Entry/exit point of every task: 1 unit after a rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    model_clear();
    chk("rst_state", state, 4'b0001);
    chk("rst_ret", ret_addr, '0);
    chk("rst_err", stack_err, 1'b0);
  endtask

  task automatic do_halt(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      inst  = 4'($urandom);
      @(negedge clk);
      chk("halt_state", state, 4'b1000);
      chk("halt_ctrl", ctrl_now(), 12'h000);
      next_cycle();
    end
    if (halt_reset) begin
      do_reset();
    end else begin
      start = 1'b1;
      @(negedge clk);
      chk("halt_start_state", state, 4'b1000);
      chk("halt_start_ctrl", ctrl_now(), 12'h000);
      next_cycle();
      start = 1'b0;
    end
  endtask

  task automatic do_instr(input logic [3:0] op, input logic [AW-1:0] pc, input bit rst_e2);
    logic [11:0] exp;
    bit          fault;
    int          nxt;   // 0 = back to fetch, 1 = second execute cycle, 2 = halt
    // FETCH: opcode bus may carry anything, only the IR load is expected.
    inst  = 4'($urandom);
    pc_in = AW'($urandom);
    start = 1'($urandom);
    @(negedge clk);
    chk("f_state", state, 4'b0001);
    chk("f_ctrl", ctrl_now(), B_IR);
    chk("f_ret", ret_addr, model_top());
    chk("f_err", stack_err, m_err);
    next_cycle();

    // EXEC1
    inst  = op;
    pc_in = pc;
    start = 1'($urandom);
    exp   = '0;
    fault = 1'b0;
    nxt   = 0;
    case (op)
      4'd0: exp = B_ACC | B_INC;
      4'd1: exp = B_WR | B_INC;
      4'd2, 4'd5: begin exp = B_E | B_INC; nxt = 1; end
      4'd3: exp = B_PL;
      4'd4: nxt = 2;
      4'd6: if (rq.size() < DEPTH) exp = B_PL; else fault = 1'b1;
      4'd7: if (rq.size() > 0) exp = B_PL | B_PS | B_ACC; else fault = 1'b1;
      default: exp = B_ACC | B_MUX | B_INC | {9'd0, op[2:0]};
    endcase
    if (fault) begin
`ifdef STACK_ERR_HALT_EN
      exp = '0;
      nxt = 2;
`else
      exp = B_INC;
`endif
    end
    @(negedge clk);
    chk("x1_state", state, 4'b0010);
    chk("x1_ctrl", ctrl_now(), exp);
    chk("x1_ret", ret_addr, model_top());
    chk("x1_err", stack_err, m_err);
    if (fault) m_err = 1'b1;
    else if (op == 4'd6) rq.push_back(pc + AW'(1));
    else if (op == 4'd7) void'(rq.pop_back());
    next_cycle();

    if (nxt == 1) begin
      if (rst_e2) reset = 1'b1;
      @(negedge clk);
      chk("x2_state", state, 4'b0100);
      chk("x2_ctrl", ctrl_now(), B_ACC | B_E | ((op == 4'd2) ? B_MUX : 12'h000));
      chk("x2_ret", ret_addr, model_top());
      next_cycle();
      if (rst_e2) begin
        reset = 1'b0;
        model_clear();
        chk("rst_e2_state", state, 4'b0001);
        chk("rst_e2_ret", ret_addr, '0);
        chk("rst_e2_err", stack_err, 1'b0);
      end
    end else if (nxt == 2) begin
      do_halt(5);
    end
  endtask

  initial begin
    logic [3:0] op;
    reset      = 1'b1;
    start      = 1'b0;
    inst       = 4'd0;
    pc_in      = '0;
    halt_reset = 1'b0;
    model_clear();
    do_reset();

    // LDI, ADD, STP with halt hold and restart.
    do_instr(4'd0, 8'h00, 1'b0);
    do_instr(4'd2, 8'h01, 1'b0);
    do_instr(4'd4, 8'h02, 1'b0);

    // Call/return with PC wrap on the pushed address.
    do_instr(4'd6, 8'h10, 1'b0);
    do_instr(4'd6, 8'hFF, 1'b0);
    chk("wrap_top", ret_addr, 8'h00);
    do_instr(4'd7, 8'h00, 1'b0);
    chk("ret_after_pop", ret_addr, 8'h11);
    do_instr(4'd7, 8'h11, 1'b0);
    chk("ret_empty", ret_addr, 8'h00);

    // Overflow on the fifth call, then underflow after draining.
    for (int i = 0; i < 5; i++) do_instr(4'd6, AW'($urandom), 1'b0);
    chk("ovf_err", stack_err, 1'b1);
    for (int i = 0; i < 5; i++) do_instr(4'd7, AW'($urandom), 1'b0);
    chk("unf_err", stack_err, 1'b1);

    // Reset while halted.
    halt_reset = 1'b1;
    do_instr(4'd4, 8'h40, 1'b0);
    halt_reset = 1'b0;

    // Reset during EXEC2 of LDA with two entries stacked and the error flag set.
    do_instr(4'd7, 8'h00, 1'b0);
    do_instr(4'd6, 8'h1F, 1'b0);
    do_instr(4'd6, 8'h2F, 1'b0);
    do_instr(4'd5, 8'h50, 1'b1);

    // Randomized instruction stream biased toward stack traffic.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      op = 4'($urandom);
      if ($urandom_range(0, 2) == 0) op = ($urandom_range(0, 1) == 0) ? 4'd6 : 4'd7;
      do_instr(op, AW'($urandom), 1'b0);
    end
    do_instr(4'd0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
